// File: rtl/tx_stage_4b.sv
// Transmit stage: serializes a 10-bit result plus carry into a short nibble frame
// with valid/ready on both sides; the next result is accepted on the final take.
module tx_stage_4b #(
    parameter bit         HDR_EN  = 1'b1,
    parameter logic [3:0] HDR_VAL = 4'hA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [9:0] res_q,
    input  logic       carry_q,
    output logic [3:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       busy
);

    // With the header omitted the index is shifted so one nibble mux serves both builds
    localparam logic [1:0] LAST = HDR_EN ? 2'd3 : 2'd2;
    localparam logic [1:0] OFS  = HDR_EN ? 2'd0 : 2'd1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [9:0] frm_res_q, frm_res_d;
    logic       frm_cy_q, frm_cy_d;

    logic       take;
    logic       accept;
    logic       last;
    logic [1:0] sel;

    assign last      = (state_q == SEND) && (idx_q == LAST);
    assign tx_valid  = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign tx_last   = last;
    assign take      = tx_valid && tx_ready;
    assign res_ready = (state_q == IDLE) || (take && last);
    assign accept    = res_valid && res_ready;
    assign sel       = idx_q + OFS;

    always_comb begin
        tx_data = 4'h0;
        if (state_q == SEND) begin
            case (sel)
                2'd0:    tx_data = HDR_VAL;
                2'd1:    tx_data = frm_res_q[3:0];
                2'd2:    tx_data = frm_res_q[7:4];
                default: tx_data = {1'b0, frm_cy_q, frm_res_q[9:8]};
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frm_res_d = frm_res_q;
        frm_cy_d  = frm_cy_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    frm_res_d = res_q;
                    frm_cy_d  = carry_q;
                    idx_d     = 2'd0;
                    state_d   = SEND;
                end
            end
            default: begin
                if (take) begin
                    if (!last) begin
                        idx_d = idx_q + 2'd1;
                    end else if (accept) begin
                        frm_res_d = res_q;
                        frm_cy_d  = carry_q;
                        idx_d     = 2'd0;
                    end else begin
                        idx_d   = 2'd0;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            frm_res_q <= 10'd0;
            frm_cy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            frm_res_q <= frm_res_d;
            frm_cy_q  <= frm_cy_d;
        end
    end

endmodule

// File: tb/tb_tx_stage_4b.sv
// Bench for tx_stage_4b: a header build and a headerless build share stimulus and are
// each checked every cycle against a queue-of-pending-nibbles model.
module tb_tx_stage_4b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       res_valid;
    logic [9:0] res_q;
    logic       carry_q;
    logic       tx_ready;

    logic [1:0] rr, tv, tl, bz;
    logic [3:0] td [2];

    int n_chk  = 0;
    int n_fail = 0;

    // Per build: nibbles of the held frame still to be sent, and a log of taken nibbles
    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    logic [3:0] log0 [$];
    logic [3:0] log1 [$];

    always #5 clk = ~clk;

    tx_stage_4b #(.HDR_EN(1'b0), .HDR_VAL(4'hA)) dut0 (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(rr[0]),
        .res_q(res_q), .carry_q(carry_q), .tx_data(td[0]), .tx_valid(tv[0]),
        .tx_ready(tx_ready), .tx_last(tl[0]), .busy(bz[0])
    );

    tx_stage_4b #(.HDR_EN(1'b1), .HDR_VAL(4'hA)) dut1 (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_ready(rr[1]),
        .res_q(res_q), .carry_q(carry_q), .tx_data(td[1]), .tx_valid(tv[1]),
        .tx_ready(tx_ready), .tx_last(tl[1]), .busy(bz[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] nib(input int k, input logic [9:0] r, input logic c);
        case (k)
            0:       return r[3:0];
            1:       return r[7:4];
            default: return {1'b0, c, r[9:8]};
        endcase
    endfunction

    function automatic int qsz(input int i);
        return (i == 1) ? q1.size() : q0.size();
    endfunction

    function automatic logic [3:0] qhd(input int i);
        if (qsz(i) == 0) return 4'h0;
        return (i == 1) ? q1[0] : q0[0];
    endfunction

    task automatic chk_outputs();
        int sz;
        for (int i = 0; i < 2; i++) begin
            sz = qsz(i);
            chk($sformatf("d%0d_tx_valid", i), 32'(tv[i]), 32'(sz != 0));
            chk($sformatf("d%0d_tx_data", i), 32'(td[i]), 32'(qhd(i)));
            chk($sformatf("d%0d_tx_last", i), 32'(tl[i]), 32'(sz == 1));
            chk($sformatf("d%0d_busy", i), 32'(bz[i]), 32'(sz != 0));
            chk($sformatf("d%0d_res_ready", i), 32'(rr[i]),
                32'((sz == 0) || (tx_ready && sz == 1)));
        end
    endtask

    // Check mid-cycle, then advance the model across the next rising edge
    task automatic cycle();
        int  sz;
        bit  acc, tk;
        #4;
        chk_outputs();
        @(posedge clk);
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                sz  = qsz(i);
                acc = res_valid && ((sz == 0) || (tx_ready && sz == 1));
                tk  = (sz != 0) && tx_ready;
                if (tk) begin
                    if (i == 1) log1.push_back(q1.pop_front());
                    else        log0.push_back(q0.pop_front());
                end
                if (acc) begin
                    if (i == 1) q1.push_back(4'hA);
                    for (int k = 0; k < 3; k++) begin
                        if (i == 1) q1.push_back(nib(k, res_q, carry_q));
                        else        q0.push_back(nib(k, res_q, carry_q));
                    end
                end
            end
        end
        #1;
    endtask

    task automatic drain();
        res_valid = 1'b0;
        tx_ready  = 1'b1;
        repeat (6) cycle();
        log0.delete();
        log1.delete();
    endtask

    task automatic chk_log(input string tag, input bit which, input logic [3:0] e [$]);
        logic [31:0] got;
        int n;
        n = which ? log1.size() : log0.size();
        chk({tag, "_len"}, 32'(n), 32'(e.size()));
        for (int i = 0; i < e.size(); i++) begin
            got = 32'hFFFF;
            if (i < n) got = 32'(which ? log1[i] : log0[i]);
            chk($sformatf("%s_n%0d", tag, i), got, 32'(e[i]));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res_q     = 10'h0;
        carry_q   = 1'b0;
        tx_ready  = 1'b1;

        // Reset values, with tx_ready high in idle having no effect
        repeat (2) cycle();
        rst_n = 1'b1;
        drain();

        // Basic frame
        res_valid = 1'b1; res_q = 10'h2D7; carry_q = 1'b1;
        cycle();
        res_valid = 1'b0;
        repeat (5) cycle();
        chk_log("basic_h1", 1'b1, '{4'hA, 4'h7, 4'hD, 4'h6});
        chk_log("basic_h0", 1'b0, '{4'h7, 4'hD, 4'h6});
        drain();

        // Backpressure on the second nibble
        res_valid = 1'b1; res_q = 10'h2D7; carry_q = 1'b1;
        cycle();
        res_valid = 1'b0;
        cycle();
        tx_ready = 1'b0;
        repeat (3) cycle();
        tx_ready = 1'b1;
        repeat (5) cycle();
        chk_log("bp_h1", 1'b1, '{4'hA, 4'h7, 4'hD, 4'h6});
        chk_log("bp_h0", 1'b0, '{4'h7, 4'hD, 4'h6});
        drain();

        // Back-to-back with res_valid held until the second result is accepted
        res_valid = 1'b1; res_q = 10'h3FF; carry_q = 1'b0;
        cycle();
        res_q = 10'h001; carry_q = 1'b1;
        repeat (4) cycle();
        res_valid = 1'b0;
        repeat (5) cycle();
        chk_log("b2b_h1", 1'b1, '{4'hA, 4'hF, 4'hF, 4'h3, 4'hA, 4'h1, 4'h0, 4'h4});
        chk_log("b2b_h0", 1'b0, '{4'hF, 4'hF, 4'h3, 4'h1, 4'h0, 4'h4});
        drain();

        // Input isolation: a new value presented mid-frame is taken only on the last take
        res_valid = 1'b1; res_q = 10'h2D7; carry_q = 1'b1;
        cycle();
        res_q = 10'h000; carry_q = 1'b0;
        repeat (4) cycle();
        res_valid = 1'b0;
        repeat (5) cycle();
        chk_log("iso_h1", 1'b1, '{4'hA, 4'h7, 4'hD, 4'h6, 4'hA, 4'h0, 4'h0, 4'h0});
        chk_log("iso_h0", 1'b0, '{4'h7, 4'hD, 4'h6, 4'h0, 4'h0, 4'h0});
        drain();

        // Header omitted
        res_valid = 1'b1; res_q = 10'h155; carry_q = 1'b0;
        cycle();
        res_valid = 1'b0;
        repeat (5) cycle();
        chk_log("nohdr_h0", 1'b0, '{4'h5, 4'h5, 4'h1});
        chk_log("nohdr_h1", 1'b1, '{4'hA, 4'h5, 4'h5, 4'h1});
        drain();

        // Asynchronous reset mid-frame, then a fresh frame from the header
        res_valid = 1'b1; res_q = 10'h3C5; carry_q = 1'b1;
        cycle();
        res_valid = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_d%0d_tx_valid", i), 32'(tv[i]), 32'd0);
            chk($sformatf("rst_d%0d_tx_last", i), 32'(tl[i]), 32'd0);
            chk($sformatf("rst_d%0d_tx_data", i), 32'(td[i]), 32'd0);
            chk($sformatf("rst_d%0d_busy", i), 32'(bz[i]), 32'd0);
            chk($sformatf("rst_d%0d_res_ready", i), 32'(rr[i]), 32'd1);
        end
        q0.delete();
        q1.delete();
        cycle();
        rst_n = 1'b1;
        log0.delete();
        log1.delete();
        cycle();
        res_valid = 1'b1; res_q = 10'h2D7; carry_q = 1'b1;
        cycle();
        res_valid = 1'b0;
        repeat (5) cycle();
        chk_log("postrst_h1", 1'b1, '{4'hA, 4'h7, 4'hD, 4'h6});
        chk_log("postrst_h0", 1'b0, '{4'h7, 4'hD, 4'h6});
        drain();

        // Randomized traffic and backpressure
        for (int n = 0; n < 600; n++) begin
            res_valid = 1'($urandom_range(0, 1));
            res_q     = 10'($urandom);
            carry_q   = 1'($urandom);
            tx_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
